// File: rtl/cla_pkg.sv
// cla_pkg: shared carry-lookahead helpers and parameter checks for pipelined_cla_addsub
`define CLA_CHECK_DIVISIBLE(W, B) \
  if (((W) % (B)) != 0 || (B) < 2 || (B) > cla_pkg::CLA_MAX_BLOCK || (W) < cla_pkg::CLA_MIN_WIDTH) begin : g_cla_param_check \
    $error("cla: WIDTH must be a multiple of BLOCK, BLOCK in 2..64, WIDTH >= 4"); \
  end

package cla_pkg;
  localparam int CLA_MIN_WIDTH = 4;
  localparam int CLA_MAX_BLOCK = 64;

  // Sum-of-products lookahead: carry into bit i+1 is any lower generate whose
  // propagate chain reaches bit i, or cin when the whole chain propagates.
  function automatic logic [CLA_MAX_BLOCK:0] cla_group_carries(
    input logic [CLA_MAX_BLOCK-1:0] g,
    input logic [CLA_MAX_BLOCK-1:0] p,
    input logic cin,
    input int unsigned n = CLA_MAX_BLOCK
  );
    logic [CLA_MAX_BLOCK:0] c;
    logic run_p;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < int'(n); i++) begin
      run_p = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (g[j] & run_p);
        run_p = run_p & p[j];
      end
      c[i+1] = c[i+1] | (cin & run_p);
    end
    return c;
  endfunction
endpackage

// File: rtl/pipelined_cla_addsub_group.sv
// cla_group: combinational BLOCK-bit carry-lookahead group with group generate/propagate
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_slice,
  input  logic [BLOCK-1:0] b_slice,
  input  logic             c_in,
  output logic [BLOCK-1:0] sum_slice,
  output logic             c_out,
  output logic             grp_g,
  output logic             grp_p
);
  logic [BLOCK-1:0] g, p;
  logic [CLA_MAX_BLOCK-1:0] g_ext, p_ext;
  logic [BLOCK:0] c, c0;
  // bit g/p, carries from c_in for the sum, carries from zero for the group generate
  always_comb begin
    g = a_slice & b_slice;
    p = a_slice ^ b_slice;
    g_ext = '0;
    p_ext = '0;
    g_ext[BLOCK-1:0] = g;
    p_ext[BLOCK-1:0] = p;
    c = (BLOCK+1)'(cla_group_carries(g_ext, p_ext, c_in, BLOCK));
    c0 = (BLOCK+1)'(cla_group_carries(g_ext, p_ext, 1'b0, BLOCK));
    sum_slice = p ^ c[BLOCK-1:0];
    c_out = c[BLOCK];
    grp_g = c0[BLOCK];
    grp_p = &p;
  end
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: valid/ready pipelined CLA adder/subtractor, one BLOCK group per stage.
// Optional macro CLA_STATUS_FLAGS_EN adds registered zero/neg outputs.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
`ifdef CLA_STATUS_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);
  localparam int STAGES = WIDTH / BLOCK;
  localparam int L = STAGES - 1;

  `CLA_CHECK_DIVISIBLE(WIDTH, BLOCK)

  logic advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i, b_i, s_i, s_nx, a_q, b_q, s_q;
    logic c_i, v_i, sub_i, c_q, v_q, sub_q;
    logic [BLOCK-1:0] sum;
    logic c_out, grp_g, grp_p, unused_c_out;
    if (k == 0) begin : g_in
      assign a_i = a;
      assign b_i = sub ? ~b : b;
      assign s_i = '0;
      assign c_i = sub | cin;
      assign v_i = in_valid;
      assign sub_i = sub;
    end else begin : g_in
      assign a_i = g_stage[k-1].a_q;
      assign b_i = g_stage[k-1].b_q;
      assign s_i = g_stage[k-1].s_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].v_q;
      assign sub_i = g_stage[k-1].sub_q;
    end
    cla_group #(.BLOCK(BLOCK)) u_group (
      .a_slice  (a_i[k*BLOCK +: BLOCK]),
      .b_slice  (b_i[k*BLOCK +: BLOCK]),
      .c_in     (c_i),
      .sum_slice(sum),
      .c_out    (c_out),
      .grp_g    (grp_g),
      .grp_p    (grp_p)
    );
    assign unused_c_out = c_out;
    // merge this group's sum bits into the deskewed partial result
    always_comb begin
      s_nx = s_i;
      s_nx[k*BLOCK +: BLOCK] = sum;
    end
    // move the beat one stage forward whenever the whole pipeline advances
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
      end else if (advance) begin
        v_q   <= v_i;
        a_q   <= a_i;
        b_q   <= b_i;
        s_q   <= s_nx;
        c_q   <= grp_g | (grp_p & c_i);
        sub_q <= sub_i;
      end
  end

  logic ovf_q, unused_tail;
  assign out_valid = g_stage[L].v_q;
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  assign s = g_stage[L].s_q;
  assign cout = g_stage[L].c_q;
  assign overflow = ovf_q;
  assign unused_tail = ^{g_stage[L].a_q, g_stage[L].b_q, g_stage[L].sub_q};

  // signed overflow judged on the final sum against the operands actually added
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (advance) ovf_q <= (g_stage[L].a_i[WIDTH-1] == g_stage[L].b_i[WIDTH-1]) &
                               (g_stage[L].s_nx[WIDTH-1] != g_stage[L].a_i[WIDTH-1]);

`ifdef CLA_STATUS_FLAGS_EN
  logic zero_q, neg_q;
  assign zero = zero_q;
  assign neg = neg_q;
  // status flags registered with the result so they share its timing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (advance) begin
      zero_q <= ~|g_stage[L].s_nx;
      neg_q  <= g_stage[L].s_nx[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed and reference-model checks of pipelined_cla_addsub
module tb_pipelined_cla_addsub;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [31:0] a, b, s;
  logic r_in_valid, r_out_ready, r_cin, r_sub;
  logic [63:0] r_a, r_b;
  logic i16_ready, o16_valid, o16_cout, o16_ovf;
  logic [15:0] o16_s;
  logic i64_ready, o64_valid, o64_cout, o64_ovf;
  logic [63:0] o64_s;
`ifdef CLA_STATUS_FLAGS_EN
  logic zero, neg, z16, n16, z64, n64;
`endif
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .overflow(overflow)
`ifdef CLA_STATUS_FLAGS_EN
    , .zero(zero), .neg(neg)
`endif
  );

  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(i16_ready),
    .a(r_a[15:0]), .b(r_b[15:0]), .cin(r_cin), .sub(r_sub), .out_valid(o16_valid),
    .out_ready(r_out_ready), .s(o16_s), .cout(o16_cout), .overflow(o16_ovf)
`ifdef CLA_STATUS_FLAGS_EN
    , .zero(z16), .neg(n16)
`endif
  );

  pipelined_cla_addsub #(.WIDTH(64), .BLOCK(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(i64_ready),
    .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub), .out_valid(o64_valid),
    .out_ready(r_out_ready), .s(o64_s), .cout(o64_cout), .overflow(o64_ovf)
`ifdef CLA_STATUS_FLAGS_EN
    , .zero(z64), .neg(n64)
`endif
  );

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic sb, input int cyc);
    logic [63:0] m, be;
    logic [64:0] f;
    exp_t e;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    be = (sb ? ~y : y) & m;
    f = {1'b0, x & m} + {1'b0, be} + 65'(sb | ci);
    e.s = f[63:0] & m;
    e.c = f[w];
    e.o = (x[w-1] == be[w-1]) && (e.s[w-1] != x[w-1]);
    e.cyc = cyc;
    return e;
  endfunction

  task automatic send_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input logic vs, input logic [31:0] es,
                          input logic ec, input logic eo);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    tick();
    chk({tag, "_lat3"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_s"}, 64'(s), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
`ifdef CLA_STATUS_FLAGS_EN
    chk({tag, "_zero"}, 64'(zero), 64'(es == 32'd0));
    chk({tag, "_neg"}, 64'(neg), 64'(es[31]));
`endif
    tick();
  endtask

  initial begin
    exp_t q16[$], q64[$];
    exp_t e;
    logic [31:0] snap;
    int sent, got, stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
    snap = '0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send_one("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    send_one("sub_min", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    send_one("sub_neg", 32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send_one("sub_zero", 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    send_one("add_posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send_one("add_cin", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
    send_one("sub_cin_ign", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0);
    send_one("add_groups", 32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0);
    send_one("add_negovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    send_one("sub_posovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);

    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid = (sent < 8);
      a = 32'(sent); b = 32'hFFFFFFF0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (cyc == 5) snap = s;
      if (!out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        if (cyc > 5) chk("stall_hold", 64'(s), 64'(snap));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("order_s", 64'(s), 64'(32'hFFFFFFF0 + 32'(got)));
        chk("order_cout", 64'(cout), 64'd0);
        got++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("burst_sent", 64'(sent), 64'd8);
    chk("burst_delivered", 64'(got), 64'd8);

    out_ready = 1'b1; in_valid = 1'b1; b = 32'd1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_s", 64'(s), 64'd0);
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("no_stale_after_reset", 64'(stale), 64'd0);

    for (int cyc = 0; cyc < 240; cyc++) begin
      r_in_valid = (cyc < 200);
      r_a = {$urandom, $urandom}; r_b = {$urandom, $urandom};
      r_cin = 1'($urandom_range(0, 1)); r_sub = 1'($urandom_range(0, 1));
      if (cyc % 7 == 0) r_b = r_a;
      @(negedge clk);
      if (o16_valid) begin
        chk("r16_expected_pending", 64'(q16.size() != 0), 64'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          chk("r16_s", 64'(o16_s), e.s);
          chk("r16_cout", 64'(o16_cout), 64'(e.c));
          chk("r16_ovf", 64'(o16_ovf), 64'(e.o));
          chk("r16_latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (o64_valid) begin
        chk("r64_expected_pending", 64'(q64.size() != 0), 64'd1);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          chk("r64_s", o64_s, e.s);
          chk("r64_cout", 64'(o64_cout), 64'(e.c));
          chk("r64_ovf", 64'(o64_ovf), 64'(e.o));
          chk("r64_latency", 64'(cyc - e.cyc), 64'd16);
        end
      end
      if (r_in_valid && i16_ready) q16.push_back(model(16, r_a, r_b, r_cin, r_sub, cyc));
      if (r_in_valid && i64_ready) q64.push_back(model(64, r_a, r_b, r_cin, r_sub, cyc));
      @(posedge clk);
      #1;
    end
    chk("r16_drained", 64'(q16.size()), 64'd0);
    chk("r64_drained", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
